// File: rtl/mandel_pixel_scanner.sv
`default_nettype none
// ============================================================================
// mandel_pixel_scanner
//   Raster-order pixel sequencer for the mandelbrot engine: launch, wait
//   (done or timeout), then one plot write per pixel.
//   Revision: 1.0
// ============================================================================
module mandel_pixel_scanner #(
  parameter int H_RES       = 320,
  parameter int V_RES       = 240,
  parameter int TIMEOUT_PAD = 4,
  parameter int MIN_WAIT    = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [11:0] i_max_iter,
  input  logic        i_calc_done,
  input  logic [11:0] i_colour_in,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_calc,
  output logic        o_plot,
  output logic [9:0]  o_plot_x,
  output logic [9:0]  o_plot_y,
  output logic [11:0] o_plot_colour,
  output logic        o_busy,
  output logic        o_frame_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_PLOT    = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [9:0]  c_X_LAST   = 10'(H_RES - 1);
  localparam logic [9:0]  c_Y_LAST   = 10'(V_RES - 1);
  localparam logic [12:0] c_PAD      = 13'(TIMEOUT_PAD);
  localparam logic [12:0] c_MIN_WAIT = 13'(MIN_WAIT);
  localparam logic [12:0] c_WAIT_SAT = 13'h1FFF;

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  r_plot_x;
  logic [9:0]  r_plot_y;
  logic [11:0] r_plot_colour;
  logic [11:0] r_max_iter_q;
  logic [12:0] r_wait_cnt;
  logic [12:0] w_limit;
  logic        w_wait_exit;
  logic        w_last_x;
  logic        w_last_y;

  // 13-bit sum so a 4095 bound plus padding cannot wrap
  assign w_limit     = {1'b0, r_max_iter_q} + c_PAD;
  assign w_wait_exit = (i_calc_done && (r_wait_cnt >= c_MIN_WAIT)) || (r_wait_cnt >= w_limit);
  assign w_last_x    = (r_x == c_X_LAST);
  assign w_last_y    = (r_y == c_Y_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_LAUNCH;
      S_LAUNCH:  w_next = S_WAIT;
      S_WAIT:    if (w_wait_exit) w_next = S_PLOT;
      S_PLOT:    w_next = S_ADVANCE;
      S_ADVANCE: w_next = (w_last_x && w_last_y) ? S_DONE : S_LAUNCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_plot_x      <= '0;
      r_plot_y      <= '0;
      r_plot_colour <= '0;
      r_max_iter_q  <= '0;
      r_wait_cnt    <= '0;
    end else if (!i_abort) begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x          <= '0;
            r_y          <= '0;
            r_max_iter_q <= i_max_iter;
          end
        end
        S_LAUNCH: r_wait_cnt <= '0;
        S_WAIT: begin
          if (r_wait_cnt != c_WAIT_SAT) r_wait_cnt <= r_wait_cnt + 13'd1;
          if (w_wait_exit) begin
            r_plot_colour <= i_colour_in;
            r_plot_x      <= r_x;
            r_plot_y      <= r_y;
          end
        end
        S_ADVANCE: begin
          if (!(w_last_x && w_last_y)) begin
            if (w_last_x) begin
              r_x <= '0;
              r_y <= r_y + 10'd1;
            end else begin
              r_x <= r_x + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are masked by abort so an abandoned state never emits a pulse
  assign o_calc        = (r_state == S_LAUNCH) && !i_abort;
  assign o_plot        = (r_state == S_PLOT) && !i_abort;
  assign o_frame_done  = (r_state == S_DONE) && !i_abort;
  assign o_busy        = (r_state != S_IDLE);
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_plot_x      = r_plot_x;
  assign o_plot_y      = r_plot_y;
  assign o_plot_colour = r_plot_colour;

endmodule
`default_nettype wire

// File: tb/tb_mandel_pixel_scanner.sv
`default_nettype none
// Testbench for mandel_pixel_scanner: engine model drives calc_done/colour,
// a scoreboard queue predicts every plot and frame_done.
module tb_mandel_pixel_scanner;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int PAD  = 4;
  localparam int MINW = 2;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [11:0] max_iter;
  logic        calc_done;
  logic [11:0] colour_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        calc;
  logic        plot;
  logic [9:0]  plot_x;
  logic [9:0]  plot_y;
  logic [11:0] plot_colour;
  logic        busy;
  logic        frame_done;

  mandel_pixel_scanner #(
    .H_RES(H), .V_RES(V), .TIMEOUT_PAD(PAD), .MIN_WAIT(MINW)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_max_iter(max_iter), .i_calc_done(calc_done), .i_colour_in(colour_in),
    .o_x(x), .o_y(y), .o_calc(calc), .o_plot(plot),
    .o_plot_x(plot_x), .o_plot_y(plot_y), .o_plot_colour(plot_colour),
    .o_busy(busy), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int mode; int dly; int mi; int period; } vec_t;
  typedef struct { int px; int py; int col; int pcyc; } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int mode = 1, dly = 5, mi_q = 0, period_exp = 0;
  int calc_cnt = 0, plot_cnt = 0, fd_cnt = 0;
  int last_calc_cyc = -1000, last_plot_cyc = 0, first_calc_cyc = 0, exp_px = 0;
  exp_t m_e;
  int   m_k;
  int   m_lim;

  function automatic logic [11:0] col_f(int c);
    return 12'((c * 37) ^ 'hA5C);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Engine model: mode 0 pulses done dly cycles after calc, 1 never, 2 always
  initial begin
    calc_done = 1'b0;
    colour_in = col_f(0);
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      colour_in = col_f(cyc);
      case (mode)
        0:       calc_done = (cyc == last_calc_cyc + dly);
        1:       calc_done = 1'b0;
        default: calc_done = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (int'(calc) + int'(plot) + int'(frame_done) > 1)
        chk("strobe_exclusive", int'(calc) + int'(plot) + int'(frame_done), 1);
      if (calc) begin
        chk("calc_x", int'(x), exp_px % H);
        chk("calc_y", int'(y), exp_px / H);
        m_lim = mi_q + PAD;
        if (mode == 2) m_k = (MINW < m_lim) ? MINW : m_lim;
        else if (mode == 0 && (dly - 1) >= MINW && (dly - 1) <= m_lim) m_k = dly - 1;
        else m_k = m_lim;
        m_e.px   = exp_px % H;
        m_e.py   = exp_px / H;
        m_e.pcyc = cyc + m_k + 2;
        m_e.col  = int'(col_f(cyc + m_k + 1));
        q.push_back(m_e);
        if (calc_cnt == 0) first_calc_cyc = cyc;
        exp_px++;
        calc_cnt++;
        last_calc_cyc = cyc;
      end
      if (plot) begin
        if (q.size() == 0) begin
          chk("plot_unexpected", 1, 0);
        end else begin
          m_e = q.pop_front();
          chk("plot_x", int'(plot_x), m_e.px);
          chk("plot_y", int'(plot_y), m_e.py);
          chk("plot_colour", int'(plot_colour), m_e.col);
          chk("plot_cycle", cyc, m_e.pcyc);
        end
        if (period_exp != 0 && plot_cnt != 0) chk("pixel_period", cyc - last_plot_cyc, period_exp);
        plot_cnt++;
        last_plot_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("frame_done_after_last_plot", cyc - last_plot_cyc, 2);
      end
    end
  end

  task automatic begin_frame(int m, int d, int mi, int per);
    mode = m; dly = d; mi_q = mi; period_exp = per;
    exp_px = 0; calc_cnt = 0; plot_cnt = 0; fd_cnt = 0;
    max_iter = 12'(mi);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frame(int budget);
    int n;
    n = 0;
    while (fd_cnt == 0 && n < budget) begin
      tick();
      n++;
      start = (n == 7);
    end
    start = 1'b0;
    chk("frame_done_seen", fd_cnt, 1);
    chk("plots_per_frame", plot_cnt, NPIX);
    chk("calcs_per_frame", calc_cnt, NPIX);
    chk("queue_drained", q.size(), 0);
    chk("idle_busy", int'(busy), 0);
    chk("last_x_kept", int'(x), H - 1);
    chk("last_y_kept", int'(y), V - 1);
    repeat (4) tick();
    chk("single_frame_done", fd_cnt, 1);
  endtask

  vec_t tbl[6];

  initial begin
    int n;
    tbl[0] = '{0, 5, 10, 8};
    tbl[1] = '{1, 0, 10, 18};
    tbl[2] = '{2, 0, 10, 6};
    tbl[3] = '{0, 1, 0, 8};
    tbl[4] = '{0, 3, 7, 6};
    tbl[5] = '{1, 0, 0, 8};

    rst = 1'b1; start = 1'b0; abort = 1'b0; max_iter = '0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_calc", int'(calc), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_xy", int'({x, y}), 0);
    chk("rst_plot_xy", int'({plot_x, plot_y}), 0);
    chk("rst_plot_colour", int'(plot_colour), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      begin_frame(tbl[i].mode, tbl[i].dly, tbl[i].mi, tbl[i].period);
      wait_frame(NPIX * (tbl[i].period + 2) + 20);
    end

    // Abort in WAIT at pixel (2,1)
    begin_frame(1, 0, 10, 0);
    n = 0;
    while (calc_cnt < 7 && n < 500) begin tick(); n++; end
    chk("reach_pixel_2_1", calc_cnt, 7);
    repeat (3) tick();
    chk("busy_before_abort", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    q.delete();
    chk("abort_busy", int'(busy), 0);
    chk("abort_x_hold", int'(x), 2);
    chk("abort_y_hold", int'(y), 1);
    repeat (30) tick();
    chk("abort_no_plot", plot_cnt, 6);
    begin_frame(0, 5, 10, 8);
    wait_frame(NPIX * 10 + 20);

    // Widest bound, max_iter changed mid-frame
    begin_frame(1, 0, 4095, 0);
    repeat (5) tick();
    max_iter = 12'd3;
    n = 0;
    while (plot_cnt < 1 && n < 4300) begin tick(); n++; end
    chk("timeout_4099_span", last_plot_cyc - first_calc_cyc, 4101);
    n = 0;
    while (calc_cnt < 2 && n < 10) begin tick(); n++; end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    q.delete();
    chk("abort_wide_busy", int'(busy), 0);

    // Asynchronous reset in the middle of a PLOT cycle
    begin_frame(0, 5, 10, 8);
    n = 0;
    while (plot !== 1'b1 && n < 200) begin tick(); n++; end
    chk("reach_plot", int'(plot), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_plot", int'(plot), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_calc_fd", int'({calc, frame_done}), 0);
    chk("async_xy", int'({x, y}), 0);
    chk("async_plot_xy", int'({plot_x, plot_y}), 0);
    chk("async_plot_colour", int'(plot_colour), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    tick();
    begin_frame(2, 0, 10, 6);
    wait_frame(NPIX * 8 + 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
